// File: rtl/seg_mulneg_decode.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module      : seg_mulneg_decode                                             |
// | Description : Seven-segment readback decoder for the signed 2-bit           |
// |               multiplier display. Waits for a stable {dp, seg} pattern,     |
// |               decodes it to a signed product and offers it on a             |
// |               valid/ready port; illegal patterns pulse err and are counted. |
// |               Define SEG_MULNEG_FACTOR_EN to add the fac_x/fac_y outputs.   |
// | Revision    : 1.0 - initial release                                         |
// +-----------------------------------------------------------------------------+
module seg_mulneg_decode #(
    parameter int unsigned STABLE = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] seg,
    input  logic       dp,
    input  logic       out_ready,
    output logic       out_valid,
    output logic [3:0] out_val,
    output logic       err,
    output logic [7:0] err_cnt
`ifdef SEG_MULNEG_FACTOR_EN
    ,
    output logic [1:0] fac_x,
    output logic [1:0] fac_y
`endif
);

    localparam logic [7:0] c_stable_cnt = 8'(STABLE);

    typedef enum logic [0:0] {
        S_TRACK = 1'b0,
        S_HOLD  = 1'b1
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] smp_q, smp_d;
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] last_q, last_d;
    logic       none_q, none_d;
    logic [3:0] out_val_q, out_val_d;
    logic       err_q, err_d;
    logic [7:0] err_cnt_q, err_cnt_d;

    logic [2:0] w_mag;
    logic       w_mag_ok;
    logic       w_legal;
    logic [3:0] w_dec;
    logic       w_eval;

    // Decode the captured sample into a signed value and a legality flag
    always_comb begin
        w_mag    = 3'd0;
        w_mag_ok = 1'b1;
        case (smp_q[6:0])
            7'b1110111: w_mag = 3'd0;
            7'b0010010: w_mag = 3'd1;
            7'b1011101: w_mag = 3'd2;
            7'b0111010: w_mag = 3'd4;
            default:    w_mag_ok = 1'b0;
        endcase
        // -4 is not a reachable product of two 2-bit signed operands
        w_legal = w_mag_ok && !(smp_q[7] && (w_mag == 3'd4));
        w_dec   = smp_q[7] ? (4'd0 - {1'b0, w_mag}) : {1'b0, w_mag};
    end

    // A stable pattern is evaluated only once, unless nothing has been seen since reset
    assign w_eval = (cnt_q == c_stable_cnt) && (none_q || (smp_q != last_q));

    // Capture, stability counter and the TRACK/HOLD next-state logic
    always_comb begin
        smp_d     = {dp, seg};
        cnt_d     = cnt_q;
        state_d   = state_q;
        last_d    = last_q;
        none_d    = none_q;
        out_val_d = out_val_q;
        err_d     = 1'b0;
        err_cnt_d = err_cnt_q;

        if ({dp, seg} != smp_q) begin
            cnt_d = 8'd1;
        end else if (cnt_q != c_stable_cnt) begin
            cnt_d = cnt_q + 8'd1;
        end

        case (state_q)
            S_TRACK: begin
                if (w_eval) begin
                    last_d = smp_q;
                    none_d = 1'b0;
                    if (w_legal) begin
                        out_val_d = w_dec;
                        state_d   = S_HOLD;
                    end else begin
                        err_d = 1'b1;
                        if (err_cnt_q != 8'hFF) begin
                            err_cnt_d = err_cnt_q + 8'd1;
                        end
                    end
                end
            end
            S_HOLD: begin
                if (out_ready) begin
                    state_d = S_TRACK;
                end
            end
            default: state_d = S_TRACK;
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_TRACK;
            smp_q     <= 8'd0;
            cnt_q     <= 8'd0;
            last_q    <= 8'd0;
            none_q    <= 1'b1;
            out_val_q <= 4'd0;
            err_q     <= 1'b0;
            err_cnt_q <= 8'd0;
        end else begin
            state_q   <= state_d;
            smp_q     <= smp_d;
            cnt_q     <= cnt_d;
            last_q    <= last_d;
            none_q    <= none_d;
            out_val_q <= out_val_d;
            err_q     <= err_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign out_valid = (state_q == S_HOLD);
    assign out_val   = out_val_q;
    assign err       = err_q;
    assign err_cnt   = err_cnt_q;

`ifdef SEG_MULNEG_FACTOR_EN
    logic [1:0] fac_x_q, fac_x_d;
    logic [1:0] fac_y_q, fac_y_d;

    // Canonical operand pair, loaded together with out_val
    always_comb begin
        fac_x_d = fac_x_q;
        fac_y_d = fac_y_q;
        if ((state_q == S_TRACK) && w_eval && w_legal) begin
            case (w_dec)
                4'b0000: begin fac_x_d = 2'b00; fac_y_d = 2'b00; end
                4'b0001: begin fac_x_d = 2'b01; fac_y_d = 2'b01; end
                4'b1111: begin fac_x_d = 2'b01; fac_y_d = 2'b11; end
                4'b0010: begin fac_x_d = 2'b10; fac_y_d = 2'b11; end
                4'b1110: begin fac_x_d = 2'b01; fac_y_d = 2'b10; end
                4'b0100: begin fac_x_d = 2'b10; fac_y_d = 2'b10; end
                default: begin fac_x_d = 2'b00; fac_y_d = 2'b00; end
            endcase
        end
    end

    // Factor registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fac_x_q <= 2'b00;
            fac_y_q <= 2'b00;
        end else begin
            fac_x_q <= fac_x_d;
            fac_y_q <= fac_y_d;
        end
    end

    assign fac_x = fac_x_q;
    assign fac_y = fac_y_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_seg_mulneg_decode.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module      : tb_seg_mulneg_decode                                          |
// | Description : Self-checking bench for seg_mulneg_decode. Directed scenarios |
// |               plus random patterns against a history-window model.         |
// |               Honours SEG_MULNEG_FACTOR_EN for the factor outputs.          |
// | Revision    : 1.0 - initial release                                         |
// +-----------------------------------------------------------------------------+
module tb_seg_mulneg_decode;

    localparam int STB = 4;

    logic       clk;
    logic       rst;
    logic [6:0] seg;
    logic       dp;
    logic       out_ready;
    logic       out_valid;
    logic [3:0] out_val;
    logic       err;
    logic [7:0] err_cnt;
`ifdef SEG_MULNEG_FACTOR_EN
    logic [1:0] fac_x;
    logic [1:0] fac_y;
`endif

    int n_cmp;
    int n_bad;

    seg_mulneg_decode #(.STABLE(STB)) dut (
        .clk       (clk),
        .rst       (rst),
        .seg       (seg),
        .dp        (dp),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_val   (out_val),
        .err       (err),
        .err_cnt   (err_cnt)
`ifdef SEG_MULNEG_FACTOR_EN
        ,
        .fac_x     (fac_x),
        .fac_y     (fac_y)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // Stable at an edge when the last STB captured samples are identical.
    logic [7:0] hist[$];
    int         ncap;
    bit         m_valid;
    int         m_val;
    bit         m_err;
    int         m_errcnt;
    bit         m_none;
    logic [7:0] m_last;

    function automatic void ref_decode(input logic [7:0] p, output int v, output bit ok);
        int mag;
        ok = 1'b1;
        case (p[6:0])
            7'b1110111: mag = 0;
            7'b0010010: mag = 1;
            7'b1011101: mag = 2;
            7'b0111010: mag = 4;
            default: begin mag = 0; ok = 1'b0; end
        endcase
        v = p[7] ? -mag : mag;
        if (v == -4) ok = 1'b0;
    endfunction

    task automatic model_reset();
        hist.delete();
        ncap     = 0;
        m_valid  = 1'b0;
        m_val    = 0;
        m_err    = 1'b0;
        m_errcnt = 0;
        m_none   = 1'b1;
        m_last   = 8'h00;
    endtask

    task automatic model_edge();
        logic [7:0] cur;
        bit         stable;
        int         v;
        bit         ok;
        cur    = (hist.size() > 0) ? hist[$] : 8'h00;
        stable = (ncap >= STB);
        foreach (hist[i]) if (hist[i] !== cur) stable = 1'b0;
        m_err = 1'b0;
        if (m_valid) begin
            if (out_ready) m_valid = 1'b0;
        end else if (stable && (m_none || cur != m_last)) begin
            m_none = 1'b0;
            m_last = cur;
            ref_decode(cur, v, ok);
            if (ok) begin
                m_valid = 1'b1;
                m_val   = v;
            end else begin
                m_err = 1'b1;
                if (m_errcnt < 255) m_errcnt++;
            end
        end
        hist.push_back({dp, seg});
        if (hist.size() > STB) void'(hist.pop_front());
        if (ncap < 1000000) ncap++;
    endtask

    // One clock: model follows the edge, returns at the following negedge
    task automatic cyc();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic apply(input logic [7:0] p);
        dp  = p[7];
        seg = p[6:0];
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1;
        model_reset();
        #1;
        n_cmp++;
        if (out_valid !== 1'b0 || out_val !== 4'd0 || err !== 1'b0 || err_cnt !== 8'd0) begin
            n_bad++;
            $display("FAIL reset_outputs: got v=%b val=%h err=%b cnt=%0d, expected all zero",
                     out_valid, out_val, err, err_cnt);
        end
`ifdef SEG_MULNEG_FACTOR_EN
        n_cmp++;
        if (fac_x !== 2'b00 || fac_y !== 2'b00) begin
            n_bad++;
            $display("FAIL reset_fac: got %b/%b expected 00/00", fac_x, fac_y);
        end
`endif
        @(negedge clk);
    endtask

    task automatic test_legal();
        bit bad;
        out_ready = 1'b0;
        apply({1'b1, 7'b1011101});
        do_reset();
        repeat (4) cyc();
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL legal_early: out_valid=%b expected 0 after 4 edges", out_valid);
        end
        cyc();
        n_cmp++;
        if (out_valid !== 1'b1 || out_val !== 4'b1110) begin
            n_bad++;
            $display("FAIL legal_decode: got v=%b val=%b expected v=1 val=1110", out_valid, out_val);
        end
`ifdef SEG_MULNEG_FACTOR_EN
        n_cmp++;
        if (fac_x !== 2'b01 || fac_y !== 2'b10) begin
            n_bad++;
            $display("FAIL legal_fac: got %b/%b expected 01/10", fac_x, fac_y);
        end
`endif
        out_ready = 1'b1;
        cyc();
        out_ready = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL legal_accept: out_valid=%b expected 0 after transfer", out_valid);
        end
        bad = 1'b0;
        repeat (10) begin
            cyc();
            if (out_valid !== 1'b0 || err !== 1'b0) bad = 1'b1;
        end
        n_cmp++;
        if (bad) begin
            n_bad++;
            $display("FAIL legal_no_reemit: saw out_valid/err=1 expected none");
        end
    endtask

    task automatic test_glitch();
        bit saw;
        out_ready = 1'b0;
        apply({1'b0, 7'b0010010});
        do_reset();
        saw = 1'b0;
        for (int k = 0; k < 10; k++) begin
            apply((k % 2 == 0) ? {1'b0, 7'b0111010} : {1'b0, 7'b0010010});
            cyc();
            if (out_valid !== 1'b0 || err !== 1'b0) saw = 1'b1;
            cyc();
            if (out_valid !== 1'b0 || err !== 1'b0) saw = 1'b1;
        end
        n_cmp++;
        if (saw) begin
            n_bad++;
            $display("FAIL glitch_filter: saw out_valid/err=1 expected none");
        end
        apply({1'b0, 7'b0111010});
        repeat (4) cyc();
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL glitch_early: out_valid=%b expected 0", out_valid);
        end
        cyc();
        n_cmp++;
        if (out_valid !== 1'b1 || out_val !== 4'b0100) begin
            n_bad++;
            $display("FAIL glitch_hold4: got v=%b val=%b expected v=1 val=0100", out_valid, out_val);
        end
    endtask

    task automatic test_illegal();
        out_ready = 1'b0;
        apply(8'h00);
        do_reset();
        repeat (4) cyc();
        cyc();
        n_cmp++;
        if (err !== 1'b1 || err_cnt !== 8'd1 || out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL illegal_blank: got err=%b cnt=%0d v=%b expected 1/1/0", err, err_cnt, out_valid);
        end
        cyc();
        n_cmp++;
        if (err !== 1'b0) begin
            n_bad++;
            $display("FAIL illegal_pulse_width: err=%b expected 0", err);
        end
        apply({1'b1, 7'b0111010});
        repeat (4) cyc();
        cyc();
        n_cmp++;
        if (err !== 1'b1 || err_cnt !== 8'd2 || out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL illegal_neg4: got err=%b cnt=%0d v=%b expected 1/2/0", err, err_cnt, out_valid);
        end
    endtask

    task automatic test_saturation();
        int pulses;
        out_ready = 1'b0;
        apply(8'h00);
        do_reset();
        pulses = 0;
        for (int i = 0; i < 260; i++) begin
            apply((i % 2 == 0) ? 8'h00 : 8'h7F);
            for (int j = 0; j < STB; j++) begin
                cyc();
                if (err === 1'b1) pulses++;
            end
        end
        cyc();
        if (err === 1'b1) pulses++;
        n_cmp++;
        if (pulses != 260) begin
            n_bad++;
            $display("FAIL sat_pulses: got %0d err pulses expected 260", pulses);
        end
        n_cmp++;
        if (err_cnt !== 8'd255) begin
            n_bad++;
            $display("FAIL sat_count: err_cnt=%0d expected 255", err_cnt);
        end
    endtask

    task automatic test_change_in_hold();
        bit bad;
        out_ready = 1'b0;
        apply({1'b0, 7'b0010010});
        do_reset();
        repeat (5) cyc();
        n_cmp++;
        if (out_valid !== 1'b1 || out_val !== 4'b0001) begin
            n_bad++;
            $display("FAIL hold_first: got v=%b val=%b expected v=1 val=0001", out_valid, out_val);
        end
        apply({1'b1, 7'b1110111});
        bad = 1'b0;
        repeat (8) begin
            cyc();
            if (out_valid !== 1'b1 || out_val !== 4'b0001) bad = 1'b1;
        end
        n_cmp++;
        if (bad) begin
            n_bad++;
            $display("FAIL hold_frozen: value changed during HOLD, got v=%b val=%b expected 1/0001", out_valid, out_val);
        end
        out_ready = 1'b1;
        cyc();
        out_ready = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL hold_drop: out_valid=%b expected 0", out_valid);
        end
        cyc();
        n_cmp++;
        if (out_valid !== 1'b1 || out_val !== 4'b0000) begin
            n_bad++;
            $display("FAIL hold_next: got v=%b val=%b expected v=1 val=0000", out_valid, out_val);
        end
`ifdef SEG_MULNEG_FACTOR_EN
        n_cmp++;
        if (fac_x !== 2'b00 || fac_y !== 2'b00) begin
            n_bad++;
            $display("FAIL hold_fac: got %b/%b expected 00/00", fac_x, fac_y);
        end
`endif
    endtask

    task automatic test_reset_mid_hold();
        out_ready = 1'b0;
        apply({1'b0, 7'b1011101});
        do_reset();
        repeat (5) cyc();
        n_cmp++;
        if (out_valid !== 1'b1 || out_val !== 4'b0010) begin
            n_bad++;
            $display("FAIL rmh_pre: got v=%b val=%b expected v=1 val=0010", out_valid, out_val);
        end
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        n_cmp++;
        if (out_valid !== 1'b0 || out_val !== 4'd0 || err !== 1'b0 || err_cnt !== 8'd0) begin
            n_bad++;
            $display("FAIL rmh_async: got v=%b val=%h err=%b cnt=%0d expected all zero",
                     out_valid, out_val, err, err_cnt);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (4) cyc();
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL rmh_early: out_valid=%b expected 0", out_valid);
        end
        cyc();
        n_cmp++;
        if (out_valid !== 1'b1 || out_val !== 4'b0010) begin
            n_bad++;
            $display("FAIL rmh_reemit: got v=%b val=%b expected v=1 val=0010", out_valid, out_val);
        end
    endtask

    task automatic test_random();
        logic [7:0] pats[10];
        logic [7:0] p;
        int         idx;
        int         hold;
        pats = '{8'h77, 8'hF7, 8'h12, 8'h92, 8'h5D, 8'hDD, 8'h3A, 8'hBA, 8'h00, 8'h7F};
        out_ready = 1'b0;
        apply(8'h12);
        do_reset();
        for (int n = 0; n < 300; n++) begin
            idx = $urandom_range(0, 10);
            if (idx == 10) p = 8'($urandom);
            else           p = pats[idx];
            apply(p);
            hold = $urandom_range(1, 2 * STB);
            for (int h = 0; h < hold; h++) begin
                out_ready = ($urandom_range(0, 3) == 0);
                cyc();
                n_cmp++;
                if (out_valid !== m_valid || err !== m_err || err_cnt !== 8'(m_errcnt)) begin
                    n_bad++;
                    $display("FAIL rand_ctrl: got v=%b err=%b cnt=%0d expected v=%b err=%b cnt=%0d",
                             out_valid, err, err_cnt, m_valid, m_err, m_errcnt);
                end
                if (m_valid) begin
                    n_cmp++;
                    if (out_val !== 4'(m_val)) begin
                        n_bad++;
                        $display("FAIL rand_val: got %b expected %b", out_val, 4'(m_val));
                    end
                end
            end
        end
        out_ready = 1'b0;
    endtask

    initial begin
        n_cmp     = 0;
        n_bad     = 0;
        rst       = 1'b1;
        seg       = 7'd0;
        dp        = 1'b0;
        out_ready = 1'b0;
        model_reset();
        test_reset();
        test_legal();
        test_glitch();
        test_illegal();
        test_saturation();
        test_change_in_hold();
        test_reset_mid_hold();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/seg_mulneg_decode.md
# seg_mulneg_decode

Seven-segment readback decoder for the signed 2-bit multiplier display path. It samples the 7-bit segment bus and the decimal-point sign line, and waits until the pattern has been stable for a programmable number of cycles. It then decodes the pattern back to a signed product value and presents it on a valid/ready output port. Illegal patterns are flagged and counted. The block sits on the observation side of the multiplier display and is used for self-check and loopback.

## Interface
- `STABLE`, default 4: consecutive identical samples required before a pattern is evaluated (legal range 1..255).
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `seg` in 7: segment pattern, same bit order as the display driver.
- `dp` in 1: sign line, 1 = negative.
- `out_ready` in 1: consumer accepts the current value.
- `out_valid` out 1: decoded value is available.
- `out_val` out 4: signed two's-complement product, range -2..4.
- `err` out 1: one-cycle pulse when an illegal pattern is evaluated.
- `err_cnt` out 8: saturating count of illegal evaluations.
- `fac_x`, `fac_y` out 2 each: canonical 2-bit two's-complement operand pair. Present only with `SEG_MULNEG_FACTOR_EN`.

## Operation
- **Input capture:** `{dp, seg}` is registered into `smp` every cycle. `cnt` (8 bit) counts consecutive cycles with `smp` unchanged:
  - Reset to 1 when `smp` changes.
  - Incremented otherwise, saturating at `STABLE`.
- **Stability:** a pattern is stable when `cnt == STABLE`.
- **Magnitude map:**
  - 0 = 1110111
  - 1 = 0010010
  - 2 = 1011101
  - 4 = 0111010
  - Any other `seg` value is illegal.
- **Sign:** `dp` gives the sign. 0 with `dp=1` decodes to 0, which is legal. 4 with `dp=1` (-4) is illegal, because -4 is not an achievable product.
- **State machine, two states:**
  - **TRACK**, the reset state. If the sample is stable and differs from `last` (or `none` is set), the block evaluates it:
    - Legal: load `out_val`, set `out_valid`, go to HOLD.
    - Illegal: pulse `err`, increment `err_cnt` if it is below 255, stay in TRACK.
    - In both cases `last <= smp` and `none <= 0`.
    - A stable pattern equal to `last` is ignored, so each pattern is emitted or reported once.
  - **HOLD**: `out_valid=1`, and `out_val` is frozen. When `out_ready=1`, drop `out_valid` and return to TRACK. Capture and `cnt` keep running in HOLD. A pattern that becomes stable during HOLD is evaluated in the first TRACK cycle after acceptance, if it is still stable and differs from `last`.
- **Reset values:**
  - `out_valid=0`, `out_val=0`, `err=0`, `err_cnt=0`, `fac_x=fac_y=0`
  - `smp=0`, `cnt=0`, `last=0`, `none=1`, state TRACK
- **Reset mid-operation:** a pending HOLD value is discarded. The pattern present after reset is re-emitted because `none=1`.

## Timing
- Take E0 as the first edge that captures a new pattern. If the pattern is held, `cnt` reaches `STABLE` after edge E(STABLE-1), and the block evaluates at edge E(STABLE).
  - Legal pattern: `out_valid` is high from E(STABLE).
  - Illegal pattern: `err` is high for the single cycle following E(STABLE).
  - With `STABLE=4`, this is 5 edges after the pattern appears.
- **Handshake:**
  - A transfer occurs on an edge where `out_valid & out_ready`.
  - `out_valid` is low the cycle after the transfer.
  - `out_val` is stable while `out_valid=1`.
  - `out_ready` is ignored in TRACK.
- **Glitches:** a pattern that changes before `cnt` reaches `STABLE` is never evaluated. `cnt` restarts at 1.
- **`err_cnt` saturation:** at 255, further errors still pulse `err`, and the count holds at 255.

## Configuration
- `SEG_MULNEG_FACTOR_EN` defined: `fac_x`/`fac_y` ports exist and load together with `out_val`. Values:
  - 0 → (00,00)
  - 1 → (01,01)
  - -1 → (01,11)
  - 2 → (10,11)
  - -2 → (01,10)
  - 4 → (10,10)
  - Reset value is 0; held during HOLD.
- `SEG_MULNEG_FACTOR_EN` undefined: the ports and the factor logic are absent. All other behaviour is identical.

## Test plan
- **Legal decode:** reset, then hold `seg=1011101`, `dp=1`, `STABLE=4`, `out_ready=0` → `out_valid` rises after 5 edges with `out_val=-2` (4'b1110). With the macro defined, `fac_x=01`, `fac_y=10`. Assert `out_ready` for 1 cycle → `out_valid` falls and does not re-rise while the pattern is unchanged.
- **Glitch filtering:** toggle `seg` between 0010010 and 0111010 every 2 cycles with `STABLE=4` → no `out_valid` and no `err`. Then hold 0111010 with `dp=0` → `out_val=4` after 5 edges.
- **Illegal patterns:** hold `seg=0000000` → one `err` pulse and `err_cnt=1`, no `out_valid`. Then hold 0111010 with `dp=1` → a second `err` pulse and `err_cnt=2`.
- **Saturation:** apply 260 alternating distinct illegal patterns, each held `STABLE` cycles → `err_cnt` stops at 255 and `err` still pulses every time.
- **Change during HOLD:** with HOLD at value 1 and `out_ready=0`, hold `seg=1110111`, `dp=1` → no change while held. Assert `out_ready` → the first value drops, then `out_val=0` is presented 1 cycle later.
- **Reset mid-HOLD:** assert `rst` asynchronously while in HOLD → `out_valid` drops immediately and all outputs go to their reset values. On release with the pattern unchanged → the same value is re-emitted after `STABLE+1` edges.
